// File: rtl/stream_mux_2to1_rr.sv
// Two-input valid/ready stream merger with packet-aware round-robin arbitration.
// Registered output stage; y_sel tags the source channel of every beat.
module stream_mux_2to1_rr #(
  parameter int WIDTH    = 8,
  parameter bit PKT_LOCK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic             i0_valid,
  input  logic             i0_last,
  output logic             i0_ready,
  input  logic [WIDTH-1:0] i1,
  input  logic             i1_valid,
  input  logic             i1_last,
  output logic             i1_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             y_last,
  output logic             y_sel,
  input  logic             y_ready
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  logic   load;
  logic   rdy0, rdy1;
  logic   acc0, acc1;

  assign load = !y_valid || y_ready;

  // In IDLE a channel's ready looks only at the other channel's valid,
  // so no channel's ready ever depends on its own valid.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy0 = load && (!i1_valid || !prio_q);
        rdy1 = load && (!i0_valid || prio_q);
      end
      LOCK0: rdy0 = load;
      LOCK1: rdy1 = load;
      default: ;
    endcase
  end

  assign i0_ready = rdy0 && rst_n;
  assign i1_ready = rdy1 && rst_n;
  assign acc0     = i0_valid && i0_ready;
  assign acc1     = i1_valid && i1_ready;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (1'b1)
      acc0: begin
        if (i0_last || !PKT_LOCK) begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end else begin
          state_d = LOCK0;
        end
      end
      acc1: begin
        if (i1_last || !PKT_LOCK) begin
          state_d = IDLE;
          prio_d  = 1'b0;
        end else begin
          state_d = LOCK1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      y_sel   <= 1'b0;
    end else if (acc0 || acc1) begin
      y       <= acc1 ? i1 : i0;
      y_last  <= acc1 ? i1_last : i0_last;
      y_sel   <= acc1;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_2to1_rr.sv
// Randomized scoreboard bench for stream_mux_2to1_rr.
// Runs a packet-locked and a per-beat instance side by side.
module tb_stream_mux_2to1_rr;

  logic clk;
  logic rst_n;
  logic quiet;
  logic finished;
  int   total;
  int   bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int inst, input string nm,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL u%0d %s: got %0h want %0h", inst, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam bit LK = (g == 0);

    logic [7:0] i0, i1, y;
    logic       i0_valid, i0_last, i0_ready;
    logic       i1_valid, i1_last, i1_ready;
    logic       y_valid, y_last, y_sel, y_ready;
    logic [9:0] q[$];

    stream_mux_2to1_rr #(
      .WIDTH(8),
      .PKT_LOCK(LK)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i0(i0),
      .i0_valid(i0_valid),
      .i0_last(i0_last),
      .i0_ready(i0_ready),
      .i1(i1),
      .i1_valid(i1_valid),
      .i1_last(i1_last),
      .i1_ready(i1_ready),
      .y(y),
      .y_valid(y_valid),
      .y_last(y_last),
      .y_sel(y_sel),
      .y_ready(y_ready)
    );

    // Reference: packet owner (-1 = none), round-robin pointer,
    // and whether the single output slot holds a beat.
    initial begin
      int         owner;
      int         win;
      bit         prio;
      bit         full;
      bit         was_rst;
      bit         load;
      bit         v[2];
      bit         l[2];
      logic [7:0] d[2];

      owner   = -1;
      prio    = 1'b0;
      full    = 1'b0;
      was_rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
        d[c] = 8'($urandom);
        l[c] = ($urandom_range(0, 2) == 0);
        v[c] = 1'b0;
      end
      i0 = '0; i1 = '0;
      i0_valid = 1'b0; i1_valid = 1'b0;
      i0_last = 1'b0; i1_last = 1'b0;
      y_ready = 1'b0;

      while (!finished) begin
        @(posedge clk);
        #1;
        if (quiet) begin
          v[0] = 1'b0;
          v[1] = 1'b0;
          y_ready = 1'b1;
        end else begin
          v[0] = was_rst || ($urandom_range(0, 9) < 7);
          v[1] = was_rst || ($urandom_range(0, 9) < 7);
          y_ready = ($urandom_range(0, 3) != 0);
        end
        i0 = d[0]; i0_last = l[0]; i0_valid = v[0];
        i1 = d[1]; i1_last = l[1]; i1_valid = v[1];

        @(negedge clk);
        if (!rst_n) begin
          chk(g, "rst_y_valid", int'(y_valid), 0);
          chk(g, "rst_y", int'(y), 0);
          chk(g, "rst_y_last", int'(y_last), 0);
          chk(g, "rst_y_sel", int'(y_sel), 0);
          chk(g, "rst_i0_ready", int'(i0_ready), 0);
          chk(g, "rst_i1_ready", int'(i1_ready), 0);
          owner   = -1;
          prio    = 1'b0;
          full    = 1'b0;
          was_rst = 1'b1;
          q.delete();
        end else begin
          was_rst = 1'b0;
          chk(g, "y_valid", int'(y_valid), int'(full));
          load = !full || y_ready;
          win  = -1;
          if (load) begin
            if (owner >= 0) win = v[owner] ? owner : -1;
            else if (v[0] && v[1]) win = int'(prio);
            else if (v[0]) win = 0;
            else if (v[1]) win = 1;
          end
          chk(g, "acc0", int'(i0_valid && i0_ready), int'(win == 0));
          chk(g, "acc1", int'(i1_valid && i1_ready), int'(win == 1));
          if (full && !y_ready) begin
            chk(g, "hold_i0_ready", int'(i0_ready), 0);
            chk(g, "hold_i1_ready", int'(i1_ready), 0);
          end
          if (owner == 0) chk(g, "lock0_i1_ready", int'(i1_ready), 0);
          if (owner == 1) chk(g, "lock1_i0_ready", int'(i0_ready), 0);
          if (win >= 0) begin
            q.push_back({1'(win), l[win], d[win]});
            if (l[win] || !LK) begin
              owner = -1;
              prio  = (win == 0);
            end else begin
              owner = win;
            end
            full   = 1'b1;
            d[win] = 8'($urandom);
            l[win] = ($urandom_range(0, 2) == 0);
          end else if (y_ready) begin
            full = 1'b0;
          end
        end
      end
      chk(g, "drain", q.size(), 0);
    end

    logic       held;
    logic [9:0] hv;

    always @(negedge clk) begin
      logic [9:0] cur;
      logic [9:0] exp;
      cur = {y_sel, y_last, y};
      if (!rst_n) begin
        held = 1'b0;
      end else if (y_valid) begin
        if (held) chk(g, "hold_stable", int'(cur), int'(hv));
        if (y_ready) begin
          held = 1'b0;
          if (q.size() == 0) begin
            chk(g, "spurious_beat", 1, 0);
          end else begin
            exp = q.pop_front();
            chk(g, "beat", int'(cur), int'(exp));
          end
        end else begin
          held = 1'b1;
          hv   = cur;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    quiet    = 1'b0;
    finished = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      if (c == 400 || c == 900 || c == 1300) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(posedge clk);
    quiet = 1'b1;
    repeat (8) @(posedge clk);
    finished = 1'b1;
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
